weighted_sum_array: RTL and testbench

//  Parametrised successor of the first-layer weighted-sum path. Computes NNEURON dot products in parallel

---
 rtl/weighted_sum_pkg.sv | 44 ++++
 rtl/weighted_sum_array_mac_lane.sv | 94 +++++++++
 rtl/weighted_sum_array.sv | 110 +++++++++++
 tb/tb_weighted_sum_array.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weighted_sum_pkg.sv
// Shared types and helpers for the weighted-sum array: FSM state encoding,
// accumulator width rule and the signed saturation helper.
package weighted_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Working width of the saturation helper; must exceed ACC_BITS + 1.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Accumulator width large enough that NPIXEL full-scale terms cannot wrap.
    function automatic int acc_bits(input int nwbits, input int pixel_bits, input int count_bit);
        return nwbits + pixel_bits + count_bit;
    endfunction

    // Clip a wide signed value to the signed range of out_bits, flagging any clipping.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] v, input int out_bits);
        sat_t                    r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi    = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        lo    = ~hi;
        r.ovf = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/weighted_sum_array_mac_lane.sv
// One neuron lane: forms the per-pixel term, accumulates it, then on finish
// adds the bias, optionally rectifies, saturates and registers the result.
module mac_lane
    import weighted_sum_pkg::*;
#(
    parameter int NWBITS     = 16,
    parameter int COUNT_BIT  = 10,
    parameter int PIXEL_BITS = 1,
    parameter int OUT_BITS   = 24,
    parameter int RELU_EN    = 0
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     finish,
    input  logic [PIXEL_BITS-1:0]    pixel,
    input  logic signed [NWBITS-1:0] weight,
    input  logic signed [NWBITS-1:0] bias,
    output logic [OUT_BITS-1:0]      result,
    output logic                     overflow
);
    localparam int ACC_BITS  = acc_bits(NWBITS, PIXEL_BITS, COUNT_BIT);
    localparam int TERM_BITS = NWBITS + PIXEL_BITS;

    logic signed [TERM_BITS-1:0] term;
    logic signed [ACC_BITS-1:0]  term_ext;
    logic signed [ACC_BITS-1:0]  acc_q, acc_d;
    logic signed [ACC_BITS:0]    biased;
    logic signed [ACC_BITS:0]    rect;
    sat_t                        sat;
    logic [OUT_BITS-1:0]         result_q, result_d;
    logic                        overflow_q, overflow_d;
    logic                        unused_sat_hi;

    generate
        if (PIXEL_BITS == 1) begin : g_gate
            // Binary pixel simply gates the weight through.
            assign term = pixel[0] ? {{PIXEL_BITS{weight[NWBITS-1]}}, weight} : '0;
        end else begin : g_mult
            logic signed [TERM_BITS-1:0] w_ext;
            logic signed [TERM_BITS-1:0] p_ext;
            assign w_ext = {{PIXEL_BITS{weight[NWBITS-1]}}, weight};
            assign p_ext = {{NWBITS{1'b0}}, pixel};
            // Pixel is unsigned, so it is zero-extended before the signed multiply.
            assign term  = w_ext * p_ext;
        end
    endgenerate

    assign term_ext = {{(ACC_BITS-TERM_BITS){term[TERM_BITS-1]}}, term};
    assign biased   = {acc_q[ACC_BITS-1], acc_q} + {{(ACC_BITS+1-NWBITS){bias[NWBITS-1]}}, bias};
    // ReLU is applied before saturation so a clamp to zero never raises overflow.
    assign rect     = ((RELU_EN != 0) && biased[ACC_BITS]) ? '0 : biased;
    assign sat      = saturate({{(SAT_W-ACC_BITS-1){rect[ACC_BITS]}}, rect}, OUT_BITS);
    // Bits above OUT_BITS are redundant sign copies after saturation.
    assign unused_sat_hi = ^sat.val[SAT_W-1:OUT_BITS];

    // Accumulator next value: clear on new dot product, add term when a pixel is consumed.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + term_ext;
        end
    end

    // Result and overflow only update on the finish cycle and are held otherwise.
    always_comb begin
        result_d   = result_q;
        overflow_d = overflow_q;
        if (finish) begin
            result_d   = sat.val[OUT_BITS-1:0];
            overflow_d = sat.ovf;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/weighted_sum_array.sv
// NNEURON parallel dot products over a serial pixel stream with bias, optional
// ReLU and saturation. This level owns the FSM, pixel counter and lane control.
module weighted_sum_array
    import weighted_sum_pkg::*;
#(
    parameter int NWBITS     = 16,
    parameter int NPIXEL     = 784,
    parameter int COUNT_BIT  = 10,
    parameter int NNEURON    = 10,
    parameter int PIXEL_BITS = 1,
    parameter int OUT_BITS   = 24,
    parameter int RELU_EN    = 0
) (
    input  logic                        clk,
    input  logic                        reset_b,
    input  logic                        start,
    input  logic                        pixel_valid,
    input  logic [PIXEL_BITS-1:0]       pixel,
    input  logic [NNEURON*NWBITS-1:0]   weights,
    input  logic [NNEURON*NWBITS-1:0]   bias,
    output logic                        busy,
    output logic                        pixel_ready,
    output logic                        out_valid,
    output logic [NNEURON*OUT_BITS-1:0] result,
    output logic [NNEURON-1:0]          overflow
);
    state_t               state_q, state_d;
    logic [COUNT_BIT-1:0] count_q, count_d;
    logic                 lane_clear;
    logic                 lane_enable;
    logic                 lane_finish;
    logic                 last_term;

    // Start is only honoured when no dot product is in flight.
    assign lane_clear  = start && ((state_q == IDLE) || (state_q == DONE));
    assign lane_enable = (state_q == ACCUM) && pixel_valid;
    assign lane_finish = (state_q == BIAS);
    assign last_term   = (count_q == COUNT_BIT'(NPIXEL - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (lane_enable && last_term) state_d = BIAS;
            BIAS:    state_d = DONE;
            DONE:    state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy        = (state_q == ACCUM) || (state_q == BIAS);
        pixel_ready = (state_q == ACCUM);
        out_valid   = (state_q == DONE);
    end

    // Pixel counter: restarts with each dot product, advances per consumed pixel.
    always_comb begin
        count_d = count_q;
        if (lane_clear) begin
            count_d = '0;
        end else if (lane_enable) begin
            count_d = last_term ? '0 : count_q + 1'b1;
        end
    end

    // Pixel counter register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NNEURON; gi++) begin : g_lane
            mac_lane #(
                .NWBITS     (NWBITS),
                .COUNT_BIT  (COUNT_BIT),
                .PIXEL_BITS (PIXEL_BITS),
                .OUT_BITS   (OUT_BITS),
                .RELU_EN    (RELU_EN)
            ) u_lane (
                .clk      (clk),
                .reset_b  (reset_b),
                .clear    (lane_clear),
                .enable   (lane_enable),
                .finish   (lane_finish),
                .pixel    (pixel),
                .weight   (weights[gi*NWBITS +: NWBITS]),
                .bias     (bias[gi*NWBITS +: NWBITS]),
                .result   (result[gi*OUT_BITS +: OUT_BITS]),
                .overflow (overflow[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_weighted_sum_array.sv
// Bench for weighted_sum_array: three instances (gate mode, 8-bit pixels with
// narrow output, gate mode with ReLU) share stimulus and are compared against
// a plain-arithmetic dot-product model.
module tb_weighted_sum_array;
    localparam int NW = 16;
    localparam int NP = 4;
    localparam int CB = 10;
    localparam int NN = 2;

    // Per-instance configuration: 0 = gate, 1 = multibit/OUT 20, 2 = gate+ReLU.
    localparam int OB [3] = '{24, 20, 24};
    localparam int MB [3] = '{0, 1, 0};
    localparam int RL [3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start = 1'b0;
    logic pixel_valid = 1'b0;
    logic       pix1 = 1'b0;
    logic [7:0] pix8 = '0;
    logic [NN*NW-1:0] weights = '0;
    logic [NN*NW-1:0] bias = '0;

    logic busy_g, busy_m, busy_r;
    logic pr_g, pr_m, pr_r;
    logic ov_g, ov_m, ov_r;
    logic [NN*24-1:0] res_g, res_r;
    logic [NN*20-1:0] res_m;
    logic [NN-1:0] ovf_g, ovf_m, ovf_r;

    weighted_sum_array #(.NWBITS(NW), .NPIXEL(NP), .COUNT_BIT(CB), .NNEURON(NN),
        .PIXEL_BITS(1), .OUT_BITS(24), .RELU_EN(0)) dut_g (
        .clk(clk), .reset_b(reset_b), .start(start), .pixel_valid(pixel_valid),
        .pixel(pix1), .weights(weights), .bias(bias), .busy(busy_g),
        .pixel_ready(pr_g), .out_valid(ov_g), .result(res_g), .overflow(ovf_g));

    weighted_sum_array #(.NWBITS(NW), .NPIXEL(NP), .COUNT_BIT(CB), .NNEURON(NN),
        .PIXEL_BITS(8), .OUT_BITS(20), .RELU_EN(0)) dut_m (
        .clk(clk), .reset_b(reset_b), .start(start), .pixel_valid(pixel_valid),
        .pixel(pix8), .weights(weights), .bias(bias), .busy(busy_m),
        .pixel_ready(pr_m), .out_valid(ov_m), .result(res_m), .overflow(ovf_m));

    weighted_sum_array #(.NWBITS(NW), .NPIXEL(NP), .COUNT_BIT(CB), .NNEURON(NN),
        .PIXEL_BITS(1), .OUT_BITS(24), .RELU_EN(1)) dut_r (
        .clk(clk), .reset_b(reset_b), .start(start), .pixel_valid(pixel_valid),
        .pixel(pix1), .weights(weights), .bias(bias), .busy(busy_r),
        .pixel_ready(pr_r), .out_valid(ov_r), .result(res_r), .overflow(ovf_r));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction data
    int wv [NN][NP];
    int bv [NN];
    bit p1 [NP];
    int p8 [NP];

    // Captured and expected outputs per instance/lane
    longint got_res [3][NN];
    bit     got_ov  [3][NN];
    longint exp_res [3][NN];
    bit     exp_ov  [3][NN];

    int stall_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum the terms, add bias, rectify, clip to the output range.
    function automatic longint model(input int d, input int n, output bit ov);
        longint s, hi, lo;
        s = bv[n];
        for (int k = 0; k < NP; k++) begin
            if (MB[d] != 0) s += longint'(wv[n][k]) * p8[k];
            else if (p1[k]) s += wv[n][k];
        end
        if (RL[d] != 0 && s < 0) s = 0;
        hi = (64'sd1 <<< (OB[d] - 1)) - 1;
        lo = -hi - 1;
        ov = 1'b0;
        if (s > hi) begin s = hi; ov = 1'b1; end
        else if (s < lo) begin s = lo; ov = 1'b1; end
        return s;
    endfunction

    task automatic randomize_data();
        logic [15:0] r;
        for (int n = 0; n < NN; n++) begin
            for (int k = 0; k < NP; k++) begin
                r = 16'($urandom);
                wv[n][k] = $signed(r);
            end
            r = 16'($urandom);
            bv[n] = $signed(r);
        end
        for (int k = 0; k < NP; k++) begin
            p1[k] = 1'($urandom);
            p8[k] = $urandom_range(0, 255);
        end
    endtask

    // Capture DUT outputs and the model's expectation for every instance/lane.
    task automatic collect();
        for (int n = 0; n < NN; n++) begin
            got_res[0][n] = $signed(res_g[n*24 +: 24]);
            got_res[1][n] = $signed(res_m[n*20 +: 20]);
            got_res[2][n] = $signed(res_r[n*24 +: 24]);
            got_ov[0][n]  = ovf_g[n];
            got_ov[1][n]  = ovf_m[n];
            got_ov[2][n]  = ovf_r[n];
            for (int d = 0; d < 3; d++) exp_res[d][n] = model(d, n, exp_ov[d][n]);
        end
    endtask

    // Issue start in the current cycle, stream NP terms with the chosen
    // pixel_valid pattern, and return in the cycle out_valid is seen.
    task automatic run_txn(input int mode, input bit restart_mid, output int lat);
        int k, step, cyc;
        bit v;
        k = 0; step = 0;
        for (int n = 0; n < NN; n++) bias[n*NW +: NW] = bv[n][15:0];
        start = 1'b1;
        pixel_valid = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (k < NP) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (step < 7) ? bit'(stall_pat[step]) : 1'b1;
            else v = ($urandom_range(0, 2) != 0);
            step++;
            pixel_valid = v;
            if (v) begin
                pix1 = p1[k];
                pix8 = 8'(p8[k]);
                for (int n = 0; n < NN; n++) weights[n*NW +: NW] = wv[n][k][15:0];
            end else begin
                pix1 = 1'($urandom);
                pix8 = 8'($urandom);
                weights = {$urandom, $urandom};
            end
            start = restart_mid && (k == 2);
            tick();
            cyc++;
            if (v) k++;
        end
        start = 1'b0;
        while (!ov_g && cyc < 40) begin
            pixel_valid = 1'($urandom);
            weights = {$urandom, $urandom};
            tick();
            cyc++;
        end
        pixel_valid = 1'b0;
        lat = ov_g ? cyc : -1;
        collect();
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy_g, pr_g, ov_g, ovf_g, res_g} !== '0) begin
            errors++; $display("FAIL reset_gate: got %h required 0", {busy_g, pr_g, ov_g, ovf_g, res_g});
        end
        checks++;
        if ({busy_m, pr_m, ov_m, ovf_m, res_m} !== '0) begin
            errors++; $display("FAIL reset_multi: got %h required 0", {busy_m, pr_m, ov_m, ovf_m, res_m});
        end
        checks++;
        if ({busy_r, pr_r, ov_r, ovf_r, res_r} !== '0) begin
            errors++; $display("FAIL reset_relu: got %h required 0", {busy_r, pr_r, ov_r, ovf_r, res_r});
        end
        reset_b = 1'b1;
        tick();
        $display("reset: checked all instances idle and cleared");
    endtask

    task automatic load_test1();
        randomize_data();
        p1 = '{1'b1, 1'b0, 1'b1, 1'b1};
        wv[0] = '{10, 20, 30, 40};
        bv[0] = 5;
    endtask

    task automatic test_gate_basic();
        int lat;
        load_test1();
        run_txn(0, 1'b0, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL gate_latency: got %0d required 6", lat); end
        checks++;
        if (got_res[0][0] !== 85) begin errors++; $display("FAIL gate_result0: got %0d required 85", got_res[0][0]); end
        for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                errors++; $display("FAIL gate_model d%0d n%0d: got %0d/%0b required %0d/%0b",
                    d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
            end
        end
        tick();
        checks++;
        if ({ov_g, busy_g} !== 2'b00 || $signed(res_g[23:0]) !== 85) begin
            errors++; $display("FAIL gate_after_done: got ov=%0b busy=%0b res=%0d required 0 0 85",
                ov_g, busy_g, $signed(res_g[23:0]));
        end
        $display("gate_basic: lat=%0d result0=%0d", lat, got_res[0][0]);
    endtask

    task automatic test_multibit_saturate();
        int lat;
        randomize_data();
        for (int k = 0; k < NP; k++) begin p8[k] = 255; wv[0][k] = -32768; end
        bv[0] = 0;
        run_txn(0, 1'b0, lat);
        checks++;
        if (got_res[1][0] !== -524288 || got_ov[1][0] !== 1'b1) begin
            errors++; $display("FAIL multi_sat: got %0d/%0b required -524288/1", got_res[1][0], got_ov[1][0]);
        end
        for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                errors++; $display("FAIL multi_model d%0d n%0d: got %0d/%0b required %0d/%0b",
                    d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
            end
        end
        $display("multibit_saturate: lat=%0d result0=%0d ovf0=%0b", lat, got_res[1][0], got_ov[1][0]);
    endtask

    task automatic test_relu();
        int lat;
        randomize_data();
        p1 = '{1'b1, 1'b1, 1'b1, 1'b1};
        wv[0] = '{10, 20, 30, 40};
        bv[0] = 5;
        wv[1] = '{-10, -20, -10, -10};
        bv[1] = 10;
        run_txn(0, 1'b0, lat);
        checks++;
        if (got_res[2][1] !== 0 || got_ov[2][1] !== 1'b0) begin
            errors++; $display("FAIL relu_lane1: got %0d/%0b required 0/0", got_res[2][1], got_ov[2][1]);
        end
        checks++;
        if (got_res[2][0] !== 105) begin errors++; $display("FAIL relu_lane0: got %0d required 105", got_res[2][0]); end
        checks++;
        if (got_res[0][1] !== -40) begin errors++; $display("FAIL norelu_lane1: got %0d required -40", got_res[0][1]); end
        $display("relu: lane0=%0d lane1=%0d (no relu lane1=%0d)", got_res[2][0], got_res[2][1], got_res[0][1]);
    endtask

    task automatic test_stall();
        int lat;
        load_test1();
        run_txn(1, 1'b0, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL stall_latency: got %0d required 9", lat); end
        checks++;
        if (got_res[0][0] !== 85) begin errors++; $display("FAIL stall_result0: got %0d required 85", got_res[0][0]); end
        for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                errors++; $display("FAIL stall_model d%0d n%0d: got %0d/%0b required %0d/%0b",
                    d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
            end
        end
        tick();
        $display("stall: lat=%0d result0=%0d", lat, got_res[0][0]);
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int t = 0; t < 2; t++) begin
            randomize_data();
            run_txn(0, t == 0, lat);
            checks++;
            if (lat !== NP + 2) begin errors++; $display("FAIL b2b_latency t%0d: got %0d required %0d", t, lat, NP + 2); end
            for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
                checks++;
                if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                    errors++; $display("FAIL b2b_model t%0d d%0d n%0d: got %0d/%0b required %0d/%0b",
                        t, d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
                end
            end
            $display("back_to_back t%0d: lat=%0d lane0=%0d", t, lat, got_res[0][0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        randomize_data();
        start = 1'b1;
        tick();
        start = 1'b0;
        pixel_valid = 1'b1;
        pix1 = 1'b1;
        pix8 = 8'hff;
        weights = {16'h7fff, 16'h7fff};
        tick();
        tick();
        reset_b = 1'b0;
        #2;
        checks++;
        if ({busy_g, pr_g, ov_g, ovf_g, res_g, busy_m, ov_m, ovf_m, res_m, busy_r, ovf_r, res_r} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got nonzero required 0 (busy_g=%0b res_g=%h res_m=%h)",
                busy_g, res_g, res_m);
        end
        pixel_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        tick();
        run_txn(0, 1'b0, lat);
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL reset_mid_latency: got %0d required 6", lat); end
        for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
            checks++;
            if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                errors++; $display("FAIL reset_mid_model d%0d n%0d: got %0d/%0b required %0d/%0b",
                    d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
            end
        end
        tick();
        $display("reset_mid: fresh lat=%0d lane0=%0d", lat, got_res[0][0]);
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 20; t++) begin
            randomize_data();
            run_txn(2, 1'($urandom), lat);
            checks++;
            if (lat < NP + 2) begin errors++; $display("FAIL rand_latency t%0d: got %0d required >=%0d", t, lat, NP + 2); end
            for (int d = 0; d < 3; d++) for (int n = 0; n < NN; n++) begin
                checks++;
                if (got_res[d][n] !== exp_res[d][n] || got_ov[d][n] !== exp_ov[d][n]) begin
                    errors++; $display("FAIL rand_model t%0d d%0d n%0d: got %0d/%0b required %0d/%0b",
                        t, d, n, got_res[d][n], got_ov[d][n], exp_res[d][n], exp_ov[d][n]);
                end
            end
            $display("random t%0d: lat=%0d g0=%0d m0=%0d r1=%0d", t, lat, got_res[0][0], got_res[1][0], got_res[2][1]);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_gate_basic();
        test_multibit_saturate();
        test_relu();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
